// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency single-ported memory between instruction fetch and data.
// Data wins ties, but at most MAX_DBURST consecutive data grants while a fetch waits.
module mem_port_arbiter #(
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned MAX_DBURST = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_ready,
   input  logic        d_req,
   input  logic [3:0]  d_wen,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ready,
   output logic        mem_en,
   output logic [3:0]  mem_wen,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        stall_o
);

   localparam logic [2:0] LatCnt   = 3'(MEM_LAT);
   localparam logic [3:0] MaxBurst = 4'(MAX_DBURST);

   typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

   state_e      state_q;
   logic [2:0]  cnt_q;
   logic [3:0]  dburst_q;
   logic        wr_q;
   logic [31:0] i_hold_q, d_hold_q;
   logic        mem_en_q;
   logic [3:0]  mem_wen_q;
   logic [31:0] mem_addr_q, mem_wdata_q;

   logic done, grant_d, grant_i;

   // Stores complete the cycle after issue; reads wait for the memory latency.
   always_comb begin
      done    = (state_q != StIdle) && (cnt_q == (wr_q ? 3'd1 : LatCnt));
      i_ready = done && (state_q == StBusyI);
      d_ready = done && (state_q == StBusyD);
      i_rdata = i_ready ? mem_rdata : i_hold_q;
      d_rdata = (d_ready && !wr_q) ? mem_rdata : d_hold_q;
      stall_o = (i_req & ~i_ready) | (d_req & ~d_ready);
      grant_d = d_req && (!i_req || (dburst_q < MaxBurst));
      grant_i = i_req && !grant_d;
   end

   assign mem_en    = mem_en_q;
   assign mem_wen   = mem_wen_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         cnt_q       <= 3'd0;
         dburst_q    <= 4'd0;
         wr_q        <= 1'b0;
         i_hold_q    <= 32'd0;
         d_hold_q    <= 32'd0;
         mem_en_q    <= 1'b0;
         mem_wen_q   <= 4'd0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
      end else begin
         // Memory strobe and operands are live only in the issue cycle.
         mem_en_q    <= 1'b0;
         mem_wen_q   <= 4'd0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         case (state_q)
            StIdle: begin
               cnt_q <= 3'd0;
               if (grant_d) begin
                  state_q     <= StBusyD;
                  wr_q        <= |d_wen;
                  mem_en_q    <= 1'b1;
                  mem_wen_q   <= d_wen;
                  mem_addr_q  <= d_addr;
                  mem_wdata_q <= (|d_wen) ? d_wdata : 32'd0;
                  if (!i_req) begin
                     dburst_q <= 4'd0;
                  end else if (dburst_q < MaxBurst) begin
                     dburst_q <= dburst_q + 4'd1;
                  end
               end else if (grant_i) begin
                  state_q    <= StBusyI;
                  wr_q       <= 1'b0;
                  mem_en_q   <= 1'b1;
                  mem_addr_q <= i_addr;
                  dburst_q   <= 4'd0;
               end
            end
            default: begin
               cnt_q <= cnt_q + 3'd1;
               if (done) begin
                  state_q <= StIdle;
                  if (i_ready) i_hold_q <= mem_rdata;
                  if (d_ready && !wr_q) d_hold_q <= mem_rdata;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiter instances (MEM_LAT 1/3/4) share one stimulus bus,
// each scenario checks the instance whose parameters it targets.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic [3:0]  d_wen;

   logic [31:0] i_rdata [3];
   logic [31:0] d_rdata [3];
   logic [31:0] mem_addr [3];
   logic [31:0] mem_wdata [3];
   logic [31:0] mem_rdata [3];
   logic        i_ready [3];
   logic        d_ready [3];
   logic        mem_en [3];
   logic        stall_o [3];
   logic [3:0]  mem_wen [3];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'hBFC0_0000: return 32'h3C08_BFAF;
         32'h8000_0010: return 32'h1234_5678;
         default:       return a ^ 32'h5A5A_0000;
      endcase
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned Lat = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
      localparam int unsigned Mdb = (g == 1) ? 2 : 4;
      logic [31:0] pipe [4];

      mem_port_arbiter #(.MEM_LAT(Lat), .MAX_DBURST(Mdb)) u_dut (
         .clk      (clk),
         .rst      (rst),
         .i_req    (i_req),
         .i_addr   (i_addr),
         .i_rdata  (i_rdata[g]),
         .i_ready  (i_ready[g]),
         .d_req    (d_req),
         .d_wen    (d_wen),
         .d_addr   (d_addr),
         .d_wdata  (d_wdata),
         .d_rdata  (d_rdata[g]),
         .d_ready  (d_ready[g]),
         .mem_en   (mem_en[g]),
         .mem_wen  (mem_wen[g]),
         .mem_addr (mem_addr[g]),
         .mem_wdata(mem_wdata[g]),
         .mem_rdata(mem_rdata[g]),
         .stall_o  (stall_o[g])
      );

      // Memory model: data for the address issued Lat cycles earlier.
      always @(posedge clk) begin
         pipe[0] <= mem_addr[g];
         for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
      end
      assign mem_rdata[g] = mem_word(pipe[Lat-1]);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      i_req = 1'b0; d_req = 1'b0; d_wen = 4'd0;
      i_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0;
      step();
      step();
      rst = 1'b1;
      smp();
   endtask

   task automatic test_reset();
      apply_reset();
      step();
      i_req = 1'b1; d_req = 1'b1; i_addr = 32'hBFC0_0000; d_addr = 32'h8000_0010;
      step();
      rst = 1'b0;
      #1;
      for (int g = 0; g < 3; g++) begin
         checks++;
         if ({mem_en[g], mem_wen[g], mem_addr[g], mem_wdata[g], i_ready[g], d_ready[g],
              i_rdata[g], d_rdata[g]} !== 135'd0) begin
            failures++;
            $display("FAIL reset_outputs[%0d]: got en=%b wen=%h addr=%h wd=%h ir=%b dr=%b id=%h dd=%h expected all 0",
                     g, mem_en[g], mem_wen[g], mem_addr[g], mem_wdata[g], i_ready[g], d_ready[g],
                     i_rdata[g], d_rdata[g]);
         end
         checks++;
         if (stall_o[g] !== 1'b1) begin
            failures++;
            $display("FAIL reset_stall[%0d]: got %b expected 1", g, stall_o[g]);
         end
      end
      i_req = 1'b0; d_req = 1'b0;
   endtask

   task automatic test_fetch_only();
      apply_reset();
      step(); i_req = 1'b1; i_addr = 32'hBFC0_0000; smp();
      checks++;
      if (stall_o[0] !== 1'b1 || mem_en[0] !== 1'b0) begin
         failures++;
         $display("FAIL fetch_c1: got stall=%b en=%b expected stall=1 en=0", stall_o[0], mem_en[0]);
      end
      step(); smp();
      checks++;
      if (mem_en[0] !== 1'b1 || mem_addr[0] !== 32'hBFC0_0000 || mem_wen[0] !== 4'd0 ||
          stall_o[0] !== 1'b1 || i_ready[0] !== 1'b0) begin
         failures++;
         $display("FAIL fetch_issue: got en=%b addr=%h wen=%h stall=%b rdy=%b expected 1 bfc00000 0 1 0",
                  mem_en[0], mem_addr[0], mem_wen[0], stall_o[0], i_ready[0]);
      end
      step(); smp();
      checks++;
      if (i_ready[0] !== 1'b1 || i_rdata[0] !== 32'h3C08_BFAF || stall_o[0] !== 1'b0 ||
          mem_en[0] !== 1'b0) begin
         failures++;
         $display("FAIL fetch_done: got rdy=%b data=%h stall=%b en=%b expected 1 3c08bfaf 0 0",
                  i_ready[0], i_rdata[0], stall_o[0], mem_en[0]);
      end
      step(); i_req = 1'b0; smp();
      checks++;
      if (i_ready[0] !== 1'b0 || i_rdata[0] !== 32'h3C08_BFAF) begin
         failures++;
         $display("FAIL fetch_hold: got rdy=%b data=%h expected 0 3c08bfaf", i_ready[0], i_rdata[0]);
      end
   endtask

   task automatic test_priority();
      apply_reset();
      step();
      i_req = 1'b1; i_addr = 32'hBFC0_0000;
      d_req = 1'b1; d_addr = 32'h8000_0010; d_wen = 4'd0; d_wdata = 32'hDEAD_BEEF;
      step(); smp();
      checks++;
      if (mem_en[0] !== 1'b1 || mem_addr[0] !== 32'h8000_0010 || mem_wdata[0] !== 32'd0) begin
         failures++;
         $display("FAIL prio_data_issue: got en=%b addr=%h wd=%h expected 1 80000010 0",
                  mem_en[0], mem_addr[0], mem_wdata[0]);
      end
      step(); smp();
      checks++;
      if (d_ready[0] !== 1'b1 || d_rdata[0] !== 32'h1234_5678 || i_ready[0] !== 1'b0) begin
         failures++;
         $display("FAIL prio_data_done: got drdy=%b data=%h irdy=%b expected 1 12345678 0",
                  d_ready[0], d_rdata[0], i_ready[0]);
      end
      step(); d_req = 1'b0; smp();
      checks++;
      if (mem_en[0] !== 1'b0 || stall_o[0] !== 1'b1) begin
         failures++;
         $display("FAIL prio_idle: got en=%b stall=%b expected 0 1", mem_en[0], stall_o[0]);
      end
      step(); smp();
      checks++;
      if (mem_en[0] !== 1'b1 || mem_addr[0] !== 32'hBFC0_0000) begin
         failures++;
         $display("FAIL prio_fetch_issue: got en=%b addr=%h expected 1 bfc00000", mem_en[0], mem_addr[0]);
      end
      step(); smp();
      checks++;
      if (i_ready[0] !== 1'b1 || i_rdata[0] !== 32'h3C08_BFAF || d_rdata[0] !== 32'h1234_5678) begin
         failures++;
         $display("FAIL prio_fetch_done: got irdy=%b idata=%h ddata=%h expected 1 3c08bfaf 12345678",
                  i_ready[0], i_rdata[0], d_rdata[0]);
      end
      step(); i_req = 1'b0;
   endtask

   task automatic test_store();
      apply_reset();
      step(); d_req = 1'b1; d_addr = 32'h8000_0010; d_wen = 4'd0; d_wdata = 32'hDEAD_BEEF; smp();
      step(); smp();
      checks++;
      if (mem_en[1] !== 1'b1 || mem_wdata[1] !== 32'd0 || mem_wen[1] !== 4'd0) begin
         failures++;
         $display("FAIL load_issue: got en=%b wd=%h wen=%h expected 1 0 0", mem_en[1], mem_wdata[1], mem_wen[1]);
      end
      for (int c = 0; c < 2; c++) begin
         step(); smp();
         checks++;
         if (d_ready[1] !== 1'b0) begin
            failures++;
            $display("FAIL load_early[%0d]: got %b expected 0", c, d_ready[1]);
         end
      end
      step(); smp();
      checks++;
      if (d_ready[1] !== 1'b1 || d_rdata[1] !== 32'h1234_5678) begin
         failures++;
         $display("FAIL load_done: got rdy=%b data=%h expected 1 12345678", d_ready[1], d_rdata[1]);
      end
      step(); d_wen = 4'b0011; d_addr = 32'h8000_0020; d_wdata = 32'hAABB_CCDD; smp();
      step(); smp();
      checks++;
      if (mem_en[1] !== 1'b1 || mem_wen[1] !== 4'b0011 || mem_wdata[1] !== 32'hAABB_CCDD ||
          mem_addr[1] !== 32'h8000_0020 || stall_o[1] !== 1'b1) begin
         failures++;
         $display("FAIL store_issue: got en=%b wen=%b wd=%h addr=%h stall=%b expected 1 0011 aabbccdd 80000020 1",
                  mem_en[1], mem_wen[1], mem_wdata[1], mem_addr[1], stall_o[1]);
      end
      step(); smp();
      checks++;
      if (d_ready[1] !== 1'b1 || d_rdata[1] !== 32'h1234_5678 || mem_en[1] !== 1'b0 ||
          mem_wen[1] !== 4'd0 || stall_o[1] !== 1'b0) begin
         failures++;
         $display("FAIL store_done: got rdy=%b data=%h en=%b wen=%b stall=%b expected 1 12345678 0 0000 0",
                  d_ready[1], d_rdata[1], mem_en[1], mem_wen[1], stall_o[1]);
      end
      step(); d_req = 1'b0; d_wen = 4'd0; smp();
      checks++;
      if (d_ready[1] !== 1'b0 || d_rdata[1] !== 32'h1234_5678) begin
         failures++;
         $display("FAIL store_after: got rdy=%b data=%h expected 0 12345678", d_ready[1], d_rdata[1]);
      end
   endtask

   task automatic test_burst();
      logic exp_i [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic got_i [6];
      int   n = 0;
      logic prev = 1'b0;
      apply_reset();
      step();
      i_req = 1'b1; i_addr = 32'h0000_1000;
      d_req = 1'b1; d_addr = 32'h8000_0040; d_wen = 4'd0;
      for (int c = 0; c < 45 && n < 6; c++) begin
         smp();
         if (mem_en[1]) begin
            got_i[n] = (mem_addr[1] == 32'h0000_1000);
            n++;
            checks++;
            if (prev) begin
               failures++;
               $display("FAIL burst_consecutive_en: got two adjacent mem_en cycles expected gap");
            end
         end
         prev = mem_en[1];
         step();
      end
      checks++;
      if (n != 6) begin
         failures++;
         $display("FAIL burst_timeout: got %0d grants expected 6", n);
      end
      for (int k = 0; k < n; k++) begin
         checks++;
         if (got_i[k] !== exp_i[k]) begin
            failures++;
            $display("FAIL burst_order[%0d]: got fetch=%b expected fetch=%b", k, got_i[k], exp_i[k]);
         end
      end
      i_req = 1'b0; d_req = 1'b0;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      step(); d_req = 1'b1; d_addr = 32'h8000_0010; d_wen = 4'd0; smp();
      step(); smp();
      checks++;
      if (mem_en[1] !== 1'b1) begin
         failures++;
         $display("FAIL rmid_issue: got en=%b expected 1", mem_en[1]);
      end
      step();
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if ({mem_en[1], mem_wen[1], mem_addr[1], mem_wdata[1], d_ready[1], d_rdata[1]} !== 102'd0) begin
         failures++;
         $display("FAIL rmid_outputs: got en=%b wen=%h addr=%h wd=%h rdy=%b data=%h expected all 0",
                  mem_en[1], mem_wen[1], mem_addr[1], mem_wdata[1], d_ready[1], d_rdata[1]);
      end
      for (int c = 0; c < 3; c++) begin
         smp();
         checks++;
         if (d_ready[1] !== 1'b0) begin
            failures++;
            $display("FAIL rmid_no_ready[%0d]: got %b expected 0", c, d_ready[1]);
         end
         step();
      end
      rst = 1'b1;
      smp();
      checks++;
      if (mem_en[1] !== 1'b0 || d_ready[1] !== 1'b0) begin
         failures++;
         $display("FAIL rmid_release: got en=%b rdy=%b expected 0 0", mem_en[1], d_ready[1]);
      end
      step(); smp();
      checks++;
      if (mem_en[1] !== 1'b1 || mem_addr[1] !== 32'h8000_0010) begin
         failures++;
         $display("FAIL rmid_reissue: got en=%b addr=%h expected 1 80000010", mem_en[1], mem_addr[1]);
      end
      step(); step(); step(); smp();
      checks++;
      if (d_ready[1] !== 1'b1 || d_rdata[1] !== 32'h1234_5678) begin
         failures++;
         $display("FAIL rmid_done: got rdy=%b data=%h expected 1 12345678", d_ready[1], d_rdata[1]);
      end
      step(); d_req = 1'b0;
   endtask

   task automatic test_back_to_back();
      int   last = -1;
      int   issues = 0;
      int   readies = 0;
      logic prev = 1'b0;
      apply_reset();
      step(); i_req = 1'b1; i_addr = 32'h0000_0200;
      for (int c = 1; c <= 30; c++) begin
         smp();
         if (mem_en[2]) begin
            checks++;
            if (last < 0 && c != 2) begin
               failures++;
               $display("FAIL b2b_first_issue: got cycle %0d expected 2", c);
            end else if (last >= 0 && c - last != 6) begin
               failures++;
               $display("FAIL b2b_spacing: got %0d expected 6", c - last);
            end else if (prev) begin
               failures++;
               $display("FAIL b2b_consecutive_en: got adjacent mem_en at cycle %0d expected gap", c);
            end
            last = c;
            issues++;
         end
         if (i_ready[2]) begin
            checks++;
            readies++;
            if (i_rdata[2] !== 32'h5A5A_0200) begin
               failures++;
               $display("FAIL b2b_data: got %h expected 5a5a0200", i_rdata[2]);
            end
         end
         prev = mem_en[2];
         step();
      end
      checks++;
      if (issues != 5 || readies != 5) begin
         failures++;
         $display("FAIL b2b_count: got issues=%0d readies=%0d expected 5 5", issues, readies);
      end
      i_req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fetch_only();
      test_priority();
      test_store();
      test_burst();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the instruction-fetch requester and the data requester of the 5-stage MIPS pipeline.
- Each requester holds a request until it receives a one-cycle ready pulse. The block raises stall_o to freeze the pipeline while any request is outstanding.
- Data accesses have priority, with an anti-starvation limit for fetch.
- Sits between the cpu core and the memory macro.

Parameters:
- MEM_LAT, 1, memory read latency in cycles from issue to valid mem_rdata; legal range 1..4.
- MAX_DBURST, 4, maximum consecutive data grants while a fetch is pending; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held until i_ready.
- i_addr  in  32  fetch byte address; word aligned.
- i_rdata  out  32  fetch data; valid when i_ready=1.
- i_ready  out  1  one-cycle pulse marking fetch completion.
- d_req  in  1  data request; held until d_ready.
- d_wen  in  4  byte write enables; 0000 means a read.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data; valid when d_ready=1.
- d_ready  out  1  one-cycle pulse marking data completion.
- mem_en  out  1  memory access strobe; exactly one cycle per access.
- mem_wen  out  4  byte write enables to memory.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid MEM_LAT cycles after the mem_en cycle.
- stall_o  out  1  pipeline freeze.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, dburst=0. All outputs go to 0: mem_en, mem_wen, mem_addr, mem_wdata, i_ready, d_ready, i_rdata, d_rdata.
- Reset asserted mid-access: the access is abandoned, with no ready pulse. After release the arbiter restarts in IDLE. Requesters must re-present their requests.
- Registered issue: the grant decision is made in IDLE. The next cycle is the ISSUE cycle, where mem_en=1 and address, wen and wdata are registered copies of the granted requester's inputs.
- States:
  - IDLE: no access in flight.
  - BUSY_I: fetch access in flight.
  - BUSY_D: data access in flight.
  - From IDLE, the arbiter grants and moves to BUSY_I or BUSY_D.
  - In a BUSY state, cnt counts cycles from ISSUE (cnt=0).
- Read completion: at cnt==MEM_LAT the block pulses the granted ready for one cycle, copies mem_rdata into i_rdata or d_rdata, and returns to IDLE.
- Write completion (d_wen!=0): d_ready pulses in the cycle after ISSUE, regardless of MEM_LAT. d_rdata is unchanged.
- Ready-data hold: i_rdata and d_rdata hold their value until the next completion of the same requester.
- Arbitration in IDLE:
  - Only one request present: that requester is granted.
  - Both present and dburst<MAX_DBURST: data is granted.
  - Both present and dburst==MAX_DBURST: fetch is granted.
- dburst counter:
  - Increments on each data grant made while i_req=1.
  - Clears on any fetch grant, or on a data grant made while i_req=0.
  - Saturates at MAX_DBURST.
- Back-to-back throughput: a request whose ready pulse occurs in cycle N and which is re-asserted in cycle N+1 is granted in cycle N+1, so the minimum turnaround is MEM_LAT+2 cycles.
- One outstanding access at most. mem_en never asserts in two consecutive cycles.
- stall_o is combinational: (i_req & ~i_ready) | (d_req & ~d_ready). It drops in the completion cycle.
- Requests that drop before their ready pulse are protocol violations. An access already issued still completes and pulses ready.
- Address or data changes while a request waits are sampled at grant time only.
- mem_wen is 0000 for fetches. mem_wdata drives 0 for reads.

Test Plan:
1. Fetch only, MEM_LAT=1, i_addr=0xBFC00000, memory returns 0x3C08BFAF -> mem_en at cycle 2 after i_req, i_ready pulse at cycle 3 with i_rdata=0x3C08BFAF, stall_o=1 for cycles 1-2.
2. i_req and d_req read rise together (d_addr=0x80000010, data 0x12345678) -> data issued first, then d_ready with 0x12345678; fetch issued after the return to IDLE; i_ready pulses MEM_LAT+2 cycles after d_ready.
3. Store d_wen=0011, d_wdata=0xAABBCCDD, MEM_LAT=3 -> mem_wen=0011, mem_wdata=0xAABBCCDD for one cycle; d_ready pulses the cycle after ISSUE; d_rdata is unchanged.
4. MAX_DBURST=2, d_req and i_req held continuously -> grant order D, D, I, D, D, I; dburst clears after each fetch grant.
5. Assert rst low during BUSY_D with cnt=1, MEM_LAT=3 -> all outputs 0 within the same cycle, no d_ready; after release with d_req still high, a fresh issue occurs.
6. MEM_LAT=4, fetch requests back-to-back -> mem_en spacing is exactly 6 cycles; never two consecutive mem_en cycles.
